// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: execution-controller state encoding and the
// HALT instruction word. The debug unit decodes the controller's `state`
// readback with the STATE_* constants below.
package pipeline_pkg;

  typedef enum logic [2:0] {
    EXEC_IDLE  = 3'd0,
    EXEC_RUN   = 3'd1,
    EXEC_STEP  = 3'd2,
    EXEC_DRAIN = 3'd3,
    EXEC_DONE  = 3'd4
  } exec_state_t;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_RUN   = 3'd1;
  localparam logic [2:0] STATE_STEP  = 3'd2;
  localparam logic [2:0] STATE_DRAIN = 3'd3;
  localparam logic [2:0] STATE_DONE  = 3'd4;

  // Pipeline advances in every state except IDLE and DONE.
  function automatic logic state_advances(input logic [2:0] s);
    return (s == STATE_RUN) || (s == STATE_STEP) || (s == STATE_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Pipeline execution controller: generates the shared segment/PC clock
// enable, sequences run / single-step / halt-drain under debug commands.
// Optional feature macro: EXEC_CTRL_CYCLE_CNT_EN (enables cycle_count;
// otherwise cycle_count is tied to zero).
//
// state | meaning
// IDLE  | paused, pipeline frozen, waiting for a debug command
// RUN   | continuous execution until HALT fetch or cmd_halt
// STEP  | exactly one enabled cycle, then back to IDLE (or DONE)
// DRAIN | HALT fetched, retiring in-flight instructions
// DONE  | HALT retired, frozen until reset
module pipeline_exec_ctrl
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_halt,
  input  logic [31:0]      if_instruction,
  output logic             clk_en,
  output logic [2:0]       state,
  output logic             step_done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic [2:0] state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       step_done_d;
  logic       halt_det;

  assign clk_en = state_advances(state_q);
  assign state  = state_q;
  assign halted = (state_q == STATE_DONE);

  // A HALT fetched while a drain is already pending must not restart it.
  assign halt_det = clk_en && (if_instruction == HALT_INSTR) && (drain_q == 4'd0);

  // Next-state, drain countdown and step-completion decode.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    step_done_d = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        // cmd_halt has top priority and does nothing here, masking the others.
        if (!cmd_halt) begin
          if (cmd_step) begin
            state_d = STATE_STEP;
          end else if (cmd_run) begin
            state_d = (drain_q == 4'd0) ? STATE_RUN : STATE_DRAIN;
          end
        end
      end
      STATE_RUN: begin
        if (halt_det) begin
          state_d = STATE_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_halt) begin
          state_d = STATE_IDLE;
        end
      end
      STATE_STEP: begin
        step_done_d = 1'b1;
        state_d     = STATE_IDLE;
        if (halt_det) begin
          drain_d = DRAIN_LOAD;
        end else if (drain_q != 4'd0) begin
          drain_d = drain_q - 4'd1;
          if (drain_q == 4'd1) begin
            state_d = STATE_DONE;
          end
        end
      end
      STATE_DRAIN: begin
        // The pause cycle itself is enabled, so it still consumes a count.
        drain_d = (drain_q == 4'd0) ? 4'd0 : drain_q - 4'd1;
        if (drain_q <= 4'd1) begin
          state_d = STATE_DONE;
        end else if (cmd_halt) begin
          state_d = STATE_IDLE;
        end
      end
      STATE_DONE: begin
        state_d = STATE_DONE;
      end
      default: begin
        state_d = STATE_IDLE;
        drain_d = 4'd0;
      end
    endcase
  end

  // State, drain counter and step_done registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STATE_IDLE;
      drain_q   <= 4'd0;
      step_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      step_done <= step_done_d;
    end
  end

`ifdef EXEC_CTRL_CYCLE_CNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .clr  (reset),
    .en   (clk_en),
    .count(cycle_count)
  );
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl (DRAIN_CYCLES=4, CNT_W=32).
module tb_pipeline_exec_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_run, cmd_step, cmd_halt;
  logic [31:0] if_instruction;
  logic        clk_en;
  logic [2:0]  state;
  logic        step_done, halted;
  logic [31:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_exec_ctrl #(
    .DRAIN_CYCLES(4),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_run       (cmd_run),
    .cmd_step      (cmd_step),
    .cmd_halt      (cmd_halt),
    .if_instruction(if_instruction),
    .clk_en        (clk_en),
    .state         (state),
    .step_done     (step_done),
    .halted        (halted),
    .cycle_count   (cycle_count)
  );

  function automatic logic [31:0] exp_cnt(input int n);
    logic [31:0] v;
    v = 32'(n);
`ifndef EXEC_CTRL_CYCLE_CNT_EN
    v = 32'd0;
`endif
    return v;
  endfunction

  // Apply inputs for the current cycle, then return at the next negedge.
  task automatic drive(input logic r, input logic s, input logic h, input logic [31:0] ins);
    cmd_run        = r;
    cmd_step       = s;
    cmd_halt       = h;
    if_instruction = ins;
    @(negedge clk);
    cmd_run  = 1'b0;
    cmd_step = 1'b0;
    cmd_halt = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, NOP);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if (clk_en !== 1'b0) begin n_bad++; $display("FAIL reset_clk_en: got %b expected 0", clk_en); end
    n_cmp++; if (step_done !== 1'b0) begin n_bad++; $display("FAIL reset_step_done: got %b expected 0", step_done); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
  endtask

  task automatic test_run_halt_fetch();
    int en_cnt;
    logic [31:0] ins;
    logic done;
    do_reset();
    en_cnt = 0;
    done   = 1'b0;
    drive(1'b1, 1'b0, 1'b0, NOP);
    for (int i = 0; i < 20 && !done; i++) begin
      if (halted) begin
        done = 1'b1;
      end else begin
        ins = NOP;
        if (clk_en) begin
          en_cnt++;
          if (en_cnt == 3) ins = HALT_W;
        end
        drive(1'b0, 1'b0, 1'b0, ins);
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL run_halt_timeout: halted %b expected 1 within 20 cycles", halted); end
    n_cmp++; if (en_cnt !== 7) begin n_bad++; $display("FAIL run_halt_enabled_cycles: got %0d expected 7", en_cnt); end
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL run_halt_state: got %0d expected 4", state); end
    n_cmp++; if (cycle_count !== exp_cnt(7)) begin n_bad++; $display("FAIL run_halt_cycle_count: got %0d expected %0d", cycle_count, exp_cnt(7)); end
    drive(1'b1, 1'b0, 1'b0, NOP);
    drive(1'b0, 1'b1, 1'b0, NOP);
    n_cmp++; if (state !== 3'd4 || clk_en !== 1'b0) begin n_bad++; $display("FAIL done_ignores_cmds: state %0d clk_en %b expected 4 0", state, clk_en); end
    n_cmp++; if (cycle_count !== exp_cnt(7)) begin n_bad++; $display("FAIL done_cycle_count: got %0d expected %0d", cycle_count, exp_cnt(7)); end
  endtask

  task automatic test_single_step();
    logic [11:0] en_v, sd_v;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i == 0 || i == 5), 1'b0, NOP);
      en_v[i] = clk_en;
      sd_v[i] = step_done;
    end
    n_cmp++; if (en_v !== 12'h021) begin n_bad++; $display("FAIL step_clk_en_pattern: got %h expected 021", en_v); end
    n_cmp++; if (sd_v !== 12'h042) begin n_bad++; $display("FAIL step_done_pattern: got %h expected 042", sd_v); end
    n_cmp++; if (cycle_count !== exp_cnt(2)) begin n_bad++; $display("FAIL step_cycle_count: got %0d expected %0d", cycle_count, exp_cnt(2)); end
  endtask

  task automatic test_run_then_halt();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, NOP);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b0, NOP);
    n_cmp++; if (state !== 3'd1 || clk_en !== 1'b1) begin n_bad++; $display("FAIL run_before_halt: state %0d clk_en %b expected 1 1", state, clk_en); end
    drive(1'b0, 1'b0, 1'b1, NOP);
    n_cmp++; if (state !== 3'd0 || clk_en !== 1'b0) begin n_bad++; $display("FAIL run_halt_cmd: state %0d clk_en %b expected 0 0", state, clk_en); end
    n_cmp++; if (cycle_count !== exp_cnt(10)) begin n_bad++; $display("FAIL run_halt_cmd_count: got %0d expected %0d", cycle_count, exp_cnt(10)); end
  endtask

  task automatic test_drain_pause_step();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, NOP);
    drive(1'b0, 1'b0, 1'b0, HALT_W);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL drain_entry: got %0d expected 3", state); end
    drive(1'b0, 1'b0, 1'b0, HALT_W);
    drive(1'b0, 1'b0, 1'b1, HALT_W);
    n_cmp++; if (state !== 3'd0 || clk_en !== 1'b0) begin n_bad++; $display("FAIL drain_pause: state %0d clk_en %b expected 0 0", state, clk_en); end
    drive(1'b0, 1'b1, 1'b0, NOP);
    drive(1'b0, 1'b0, 1'b0, HALT_W);
    n_cmp++; if (state !== 3'd0 || step_done !== 1'b1) begin n_bad++; $display("FAIL drain_step1: state %0d step_done %b expected 0 1", state, step_done); end
    drive(1'b0, 1'b1, 1'b0, NOP);
    drive(1'b0, 1'b0, 1'b0, NOP);
    n_cmp++; if (state !== 3'd4 || halted !== 1'b1) begin n_bad++; $display("FAIL drain_step2_done: state %0d halted %b expected 4 1", state, halted); end
    n_cmp++; if (step_done !== 1'b1) begin n_bad++; $display("FAIL drain_step2_pulse: got %b expected 1", step_done); end
    n_cmp++; if (cycle_count !== exp_cnt(5)) begin n_bad++; $display("FAIL drain_step_count: got %0d expected %0d", cycle_count, exp_cnt(5)); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, NOP);
    n_cmp++; if (state !== 3'd0 || clk_en !== 1'b0) begin n_bad++; $display("FAIL prio_all_three: state %0d clk_en %b expected 0 0", state, clk_en); end
    drive(1'b1, 1'b1, 1'b0, NOP);
    n_cmp++; if (state !== 3'd2 || clk_en !== 1'b1) begin n_bad++; $display("FAIL prio_step_over_run: state %0d clk_en %b expected 2 1", state, clk_en); end
    drive(1'b0, 1'b0, 1'b0, NOP);
    drive(1'b1, 1'b0, 1'b0, NOP);
    drive(1'b1, 1'b1, 1'b0, NOP);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL run_ignores_step_run: got %0d expected 1", state); end
    drive(1'b0, 1'b0, 1'b1, HALT_W);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL prio_halt_fetch_over_cmd: got %0d expected 3", state); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, NOP);
    drive(1'b0, 1'b0, 1'b0, HALT_W);
    drive(1'b0, 1'b0, 1'b0, NOP);
    drive(1'b0, 1'b0, 1'b1, NOP);
    drive(1'b1, 1'b0, 1'b0, NOP);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL drain_resume: got %0d expected 3", state); end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, NOP);
    reset = 1'b0;
    n_cmp++; if (state !== 3'd0 || clk_en !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL reset_mid_drain: state %0d clk_en %b halted %b expected 0 0 0", state, clk_en, halted); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_mid_drain_count: got %0d expected 0", cycle_count); end
    drive(1'b1, 1'b0, 1'b0, NOP);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, NOP);
    n_cmp++; if (state !== 3'd1 || clk_en !== 1'b1) begin n_bad++; $display("FAIL run_after_reset: state %0d clk_en %b expected 1 1", state, clk_en); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    cmd_run        = 1'b0;
    cmd_step       = 1'b0;
    cmd_halt       = 1'b0;
    if_instruction = NOP;
    @(negedge clk);
    test_reset();
    test_run_halt_fetch();
    test_single_step();
    test_run_then_halt();
    test_drain_pause_step();
    test_priority();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
